jtdsp16_sdo_rx: RTL and testbench

- Receives the DSP16 serial output (sdo/ock/old) on the DSP side of the QSound core and rebuilds 16-bit audio words.
- Pairs consecutive words into left/right stereo samples.
- Hands each pair to the mixer through a valid/ready handshake with a single-pair holding buffer.
- Drives the DSP's doen pin and flags framing and overrun faults.

---
 rtl/jtdsp16_sdo_rx.sv | 194 +++++++++++++++++++
 tb/tb_jtdsp16_sdo_rx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtdsp16_sdo_rx.sv
// jtdsp16_sdo_rx
//   Receives the DSP16 serial output stream (sdo/ock/old) and rebuilds
//   DW-bit words. Consecutive words are paired as left/right samples. Each
//   pair is offered to the mixer through a valid/ready handshake backed by a
//   single-pair holding buffer. The block also drives the DSP doen pin and
//   reports sticky framing (resync_err) and overrun faults.
//
// Ports
//   clk, rst     system clock, asynchronous active-high reset
//   enable       receiver enable, also registered onto doen
//   ock/sdo/old  DSP serial clock, data, and word-load strobe (clk domain)
//   doen         data output enable to the DSP
//   left/right   held stereo pair
//   valid/ready  pair handshake to the consumer
//   overrun      sticky: a completed pair was dropped (buffer full)
//   resync_err   sticky: a partial word was aborted (early old or timeout)
//   busy         a word is being shifted in
//   clr_flags    clears overrun and resync_err (a set in the same cycle wins)
module jtdsp16_sdo_rx #(
   parameter int DW        = 16,
   parameter int MSB_FIRST = 0,
   parameter int TIMEOUT   = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   input  logic          ock,
   input  logic          sdo,
   input  logic          old,
   output logic          doen,
   output logic [DW-1:0] left,
   output logic [DW-1:0] right,
   output logic          valid,
   input  logic          ready,
   output logic          overrun,
   output logic          resync_err,
   output logic          busy,
   input  logic          clr_flags
);

   localparam int CW = $clog2(DW + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic          ock_q, old_q, doen_q;
   logic [DW-1:0] sr_q, sr_d;
   logic [DW-1:0] lstg_q, lstg_d;
   logic [DW-1:0] left_q, left_d;
   logic [DW-1:0] right_q, right_d;
   logic [CW-1:0] bcnt_q, bcnt_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          chan_q, chan_d;
   logic          valid_q, valid_d;
   logic          ovr_q, ovr_d;
   logic          rse_q, rse_d;

   logic          ock_rise, old_rise, last_bit;
   logic          word_done, set_rse, set_ovr, pair_new;
   logic [DW-1:0] sr_shift;

   assign ock_rise = ock & ~ock_q;
   assign old_rise = old & ~old_q;
   assign last_bit = (bcnt_q == CW'(DW - 1));

   // LSB-first shifts right so the first bit ends at bit 0 after DW bits.
   assign sr_shift = (MSB_FIRST != 0) ? {sr_q[DW-2:0], sdo}
                                      : {sdo, sr_q[DW-1:1]};

   // Word framing FSM. Priority inside SHIFT: disable, completing bit
   // (which may coincide with a new old strobe), early old, plain bit,
   // timeout.
   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      bcnt_d    = bcnt_q;
      tmo_d     = tmo_q;
      chan_d    = chan_q;
      lstg_d    = lstg_q;
      word_done = 1'b0;
      set_rse   = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable && old_rise) begin
               state_d = SHIFT;
               bcnt_d  = '0;
               tmo_d   = '0;
            end
         end
         SHIFT: begin
            if (!enable) begin
               state_d = IDLE;
               chan_d  = 1'b0;
            end else if (ock_rise && last_bit) begin
               // Word completes now; a simultaneous old starts the next one.
               word_done = 1'b1;
               sr_d      = sr_shift;
               chan_d    = ~chan_q;
               bcnt_d    = '0;
               tmo_d     = '0;
               state_d   = old_rise ? SHIFT : IDLE;
               if (!chan_q) lstg_d = sr_shift;
            end else if (old_rise) begin
               set_rse = 1'b1;
               chan_d  = 1'b0;
               bcnt_d  = '0;
               tmo_d   = '0;
            end else if (ock_rise) begin
               sr_d   = sr_shift;
               bcnt_d = bcnt_q + 1'b1;
               tmo_d  = '0;
            end else if (tmo_q == TW'(TIMEOUT)) begin
               set_rse = 1'b1;
               chan_d  = 1'b0;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Pair holding buffer. A new pair may replace the held one in the same
   // cycle the consumer takes it.
   assign pair_new = word_done & chan_q;

   always_comb begin
      valid_d = valid_q;
      left_d  = left_q;
      right_d = right_q;
      set_ovr = 1'b0;
      if (pair_new) begin
         if (!valid_q || ready) begin
            left_d  = lstg_q;
            right_d = sr_shift;
            valid_d = 1'b1;
         end else begin
            set_ovr = 1'b1;
         end
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end
      ovr_d = set_ovr | (ovr_q & ~clr_flags);
      rse_d = set_rse | (rse_q & ~clr_flags);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ock_q   <= 1'b0;
         old_q   <= 1'b0;
         doen_q  <= 1'b0;
         sr_q    <= '0;
         lstg_q  <= '0;
         left_q  <= '0;
         right_q <= '0;
         bcnt_q  <= '0;
         tmo_q   <= '0;
         chan_q  <= 1'b0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         rse_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ock_q   <= ock;
         old_q   <= old;
         doen_q  <= enable;
         sr_q    <= sr_d;
         lstg_q  <= lstg_d;
         left_q  <= left_d;
         right_q <= right_d;
         bcnt_q  <= bcnt_d;
         tmo_q   <= tmo_d;
         chan_q  <= chan_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         rse_q   <= rse_d;
      end
   end

   assign doen       = doen_q;
   assign left       = left_q;
   assign right      = right_q;
   assign valid      = valid_q;
   assign overrun    = ovr_q;
   assign resync_err = rse_q;
   assign busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_jtdsp16_sdo_rx.sv
// Testbench for jtdsp16_sdo_rx. Two instances share the same serial stream:
// one LSB-first and one MSB-first, so the MSB-first instance must decode the
// bit-reversed word of the LSB-first one.
module tb_jtdsp16_sdo_rx;

   localparam int TMO = 255;

   logic clk = 1'b0;
   logic rst, enable, ock, sdo, old, ready, clr_flags;

   logic        doen_l, valid_l, ovr_l, rse_l, busy_l;
   logic [15:0] left_l, right_l;
   logic        doen_m, valid_m, ovr_m, rse_m, busy_m;
   logic [15:0] left_m, right_m;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   jtdsp16_sdo_rx #(.DW(16), .MSB_FIRST(0), .TIMEOUT(TMO)) dut_lsb (
      .clk(clk), .rst(rst), .enable(enable), .ock(ock), .sdo(sdo), .old(old),
      .doen(doen_l), .left(left_l), .right(right_l), .valid(valid_l),
      .ready(ready), .overrun(ovr_l), .resync_err(rse_l), .busy(busy_l),
      .clr_flags(clr_flags)
   );

   jtdsp16_sdo_rx #(.DW(16), .MSB_FIRST(1), .TIMEOUT(TMO)) dut_msb (
      .clk(clk), .rst(rst), .enable(enable), .ock(ock), .sdo(sdo), .old(old),
      .doen(doen_m), .left(left_m), .right(right_m), .valid(valid_m),
      .ready(ready), .overrun(ovr_m), .resync_err(rse_m), .busy(busy_m),
      .clr_flags(clr_flags)
   );

   // sl/sr: bit i is the i-th bit transmitted. Expected words hand computed.
   typedef struct {
      logic [15:0] sl, sr;
      logic [15:0] el_l, er_l;
      logic [15:0] el_m, er_m;
   } vec_t;

   vec_t vt[4];

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      sdo = b;
      ock = 1'b1;
      @(negedge clk);
      ock = 1'b0;
   endtask

   task automatic pulse_old();
      @(negedge clk);
      old = 1'b1;
      @(negedge clk);
      old = 1'b0;
   endtask

   task automatic send_bits(input logic [15:0] s, input int n);
      for (int i = 0; i < n; i++) send_bit(s[i]);
   endtask

   task automatic send_word(input logic [15:0] s);
      pulse_old();
      send_bits(s, 16);
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr_flags = 1'b1;
      @(negedge clk);
      clr_flags = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{16'h1234, 16'hABCD, 16'h1234, 16'hABCD, 16'h2C48, 16'hB3D5};
      vt[1] = '{16'h2C48, 16'hB3D5, 16'h2C48, 16'hB3D5, 16'h1234, 16'hABCD};
      vt[2] = '{16'h0001, 16'h8000, 16'h0001, 16'h8000, 16'h8000, 16'h0001};
      vt[3] = '{16'h00FF, 16'hF0F0, 16'h00FF, 16'hF0F0, 16'hFF00, 16'h0F0F};

      rst = 1'b1; enable = 1'b0; ock = 1'b0; sdo = 1'b0; old = 1'b0;
      ready = 1'b1; clr_flags = 1'b0;
      tick(2);
      check("reset_outputs",
            {doen_l, valid_l, ovr_l, rse_l, busy_l, left_l, right_l},
            '0);
      check("reset_outputs_msb",
            {doen_m, valid_m, ovr_m, rse_m, busy_m, left_m, right_m},
            '0);
      @(negedge clk);
      rst = 1'b0;
      enable = 1'b1;
      @(negedge clk);
      check("doen_after_enable", {doen_l, doen_m}, 2'b11);

      // Table: pairs with ready held high
      for (int i = 0; i < 4; i++) begin
         send_word(vt[i].sl);
         pulse_old();
         send_bits(vt[i].sr, 15);
         check($sformatf("vec%0d_valid_before", i), {valid_l, valid_m}, 2'b00);
         send_bit(vt[i].sr[15]);
         check($sformatf("vec%0d_valid_latency", i), {valid_l, valid_m}, 2'b11);
         tick(1);
         check($sformatf("vec%0d_valid_single", i), {valid_l, valid_m}, 2'b00);
         check($sformatf("vec%0d_lsb_pair", i), {left_l, right_l},
               {vt[i].el_l, vt[i].er_l});
         check($sformatf("vec%0d_msb_pair", i), {left_m, right_m},
               {vt[i].el_m, vt[i].er_m});
         check($sformatf("vec%0d_flags", i), {ovr_l, rse_l, ovr_m, rse_m}, 4'b0);
      end

      // Overrun: second pair dropped while the first is held
      @(negedge clk);
      ready = 1'b0;
      send_word(16'h0001);
      send_word(16'h0002);
      tick(1);
      check("ovr_first_held", {valid_l, ovr_l, left_l, right_l},
            {1'b1, 1'b0, 16'h0001, 16'h0002});
      send_word(16'h0003);
      send_word(16'h0004);
      tick(1);
      check("ovr_lsb", {valid_l, ovr_l, left_l, right_l},
            {1'b1, 1'b1, 16'h0001, 16'h0002});
      check("ovr_msb", {valid_m, ovr_m, left_m, right_m},
            {1'b1, 1'b1, 16'h8000, 16'h4000});
      @(negedge clk);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      check("ovr_accept", {valid_l, left_l, right_l}, {1'b0, 16'h0001, 16'h0002});
      pulse_clr();
      check("ovr_clr", {ovr_l, ovr_m}, 2'b00);
      ready = 1'b1;

      // Resync: early old after 7 bits of a left word
      pulse_old();
      send_bits(16'hFFFF, 7);
      send_word(16'h5555);
      send_word(16'hAAAA);
      tick(1);
      check("resync_lsb", {rse_l, left_l, right_l}, {1'b1, 16'h5555, 16'hAAAA});
      check("resync_msb", {rse_m, left_m, right_m}, {1'b1, 16'hAAAA, 16'h5555});
      pulse_clr();
      check("resync_clr", {rse_l, rse_m}, 2'b00);

      // Resync during a right word must restart at the left channel
      send_word(16'h1111);
      pulse_old();
      send_bits(16'h0000, 7);
      send_word(16'h00FF);
      send_word(16'hF0F0);
      tick(1);
      check("resync_right_abort", {rse_l, left_l, right_l},
            {1'b1, 16'h00FF, 16'hF0F0});
      pulse_clr();

      // Timeout
      pulse_old();
      send_bits(16'h001F, 5);
      check("tmo_busy_start", {busy_l, busy_m}, 2'b11);
      tick(TMO - 5);
      check("tmo_busy_hold", {busy_l, busy_m, rse_l}, 3'b110);
      tick(6);
      check("tmo_abort", {busy_l, busy_m, rse_l, rse_m}, 4'b0011);
      pulse_clr();
      send_word(16'h0F0F);
      send_word(16'h3C3C);
      tick(1);
      check("tmo_next_lsb", {rse_l, left_l, right_l}, {1'b0, 16'h0F0F, 16'h3C3C});
      check("tmo_next_msb", {left_m, right_m}, {16'hF0F0, 16'h3C3C});

      // Reset mid-word with a held pair and a flag set
      @(negedge clk);
      ready = 1'b0;
      send_word(16'h1357);
      send_word(16'h2468);
      tick(1);
      check("rst_pre_valid", {valid_l, left_l, right_l}, {1'b1, 16'h1357, 16'h2468});
      pulse_old();
      send_bits(16'h0007, 3);
      pulse_old();
      send_bits(16'h0000, 2);
      check("rst_pre_state", {busy_l, rse_l}, 2'b11);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_mid_word",
            {doen_l, valid_l, ovr_l, rse_l, busy_l, left_l, right_l}, '0);
      @(negedge clk);
      rst = 1'b0;
      ready = 1'b1;
      @(negedge clk);
      check("rst_release_doen", doen_l, 1'b1);

      // Enable drop in the middle of a right word
      send_word(16'h1111);
      pulse_old();
      send_bits(16'h000F, 4);
      check("en_busy", busy_l, 1'b1);
      @(negedge clk);
      enable = 1'b0;
      check("en_doen_lag", doen_l, 1'b1);
      @(negedge clk);
      check("en_drop", {doen_l, busy_l, rse_l, doen_m, busy_m, rse_m}, 6'b0);
      enable = 1'b1;
      @(negedge clk);
      check("en_restore", doen_l, 1'b1);
      send_word(16'h1234);
      send_word(16'hABCD);
      tick(1);
      check("en_pair", {rse_l, left_l, right_l}, {1'b0, 16'h1234, 16'hABCD});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
